spram_multibank: RTL

Parametrised successor to the single-SPRAM 8-bit RAM. It concatenates 1–4 iCE40UP SB_SPRAM256KA banks into one linear memory, up to 128 KB. Adds:
- selectable 8- or 16-bit data path
- per-byte write masks
- a req/ready/rvalid handshake
- per-bank idle power-down, with an automatic wake sequence

It sits on the CPU/DMA memory bus in place of the older fixed 32 KB RAM.

---
 rtl/spram_pkg.sv | 27 ++
 rtl/spram_bank.sv | 91 +++++++++
 rtl/spram_multibank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared types and constants for the multi-bank SPRAM memory.
package spram_pkg;

    // Power state of one SPRAM bank
    typedef enum logic [1:0] {
        StAwake   = 2'd0,
        StStandby = 2'd1,
        StWaking  = 2'd2
    } bank_state_e;

    localparam int unsigned SPRAM_ROW_BITS  = 14;
    localparam int unsigned SPRAM_DATA_BITS = 16;
    localparam int unsigned SPRAM_MASK_BITS = 4;

    // Ceiling log2; returns 0 for n <= 1
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spram_bank.sv
// One 16K x 16 single-port RAM bank with its idle power-down / wake FSM.
module spram_bank
    import spram_pkg::*;
#(
    parameter int unsigned IDLE_SLEEP  = 1024,
    parameter int unsigned WAKE_CYCLES = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sel_i,      // accepted access to this bank
    input  logic                       hit_i,      // req addressed here, accepted or not
    input  logic                       we_i,
    input  logic [SPRAM_ROW_BITS-1:0]  row_i,
    input  logic [SPRAM_DATA_BITS-1:0] din16_i,
    input  logic [SPRAM_MASK_BITS-1:0] mask4_i,
    output logic [SPRAM_DATA_BITS-1:0] dout16_o,
    output logic                       awake_o,
    output logic                       standby_o
);

    localparam int unsigned IdleW = (IDLE_SLEEP > 1) ? clog2(IDLE_SLEEP) : 1;
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_SLEEP - 1);

    bank_state_e                state_q;
    logic [IdleW-1:0]           idle_q;
    logic [3:0]                 wake_q;
    logic [SPRAM_DATA_BITS-1:0] dout_q;
    logic [SPRAM_DATA_BITS-1:0] bit_mask;

    // Storage stands in for SB_SPRAM256KA (SLEEP=0, POWEROFF=1): contents survive standby
    logic [SPRAM_DATA_BITS-1:0] mem [1 << SPRAM_ROW_BITS];

    // Each MASKWREN bit enables one nibble of the 16-bit word
    always_comb begin
        bit_mask = {{4{mask4_i[3]}}, {4{mask4_i[2]}}, {4{mask4_i[1]}}, {4{mask4_i[0]}}};
    end

    // Array write / registered read port
    always_ff @(posedge clk_i) begin
        if (sel_i) begin
            if (we_i) begin
                mem[row_i] <= (mem[row_i] & ~bit_mask) | (din16_i & bit_mask);
            end else begin
                dout_q <= mem[row_i];
            end
        end
    end

    // Idle counting, standby entry and the timed wake sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StAwake;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            unique case (state_q)
                StAwake: begin
                    if (sel_i) begin
                        idle_q <= '0;
                    end else if ((IDLE_SLEEP != 0) && (idle_q == IdleLast)) begin
                        state_q <= StStandby;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                StStandby: begin
                    if (hit_i) begin
                        state_q <= StWaking;
                        wake_q  <= 4'(WAKE_CYCLES);
                    end
                end
                StWaking: begin
                    // Leaving on the cycle the count would hit 0 gives WAKE_CYCLES+1 stall
                    if (wake_q <= 4'd1) begin
                        state_q <= StAwake;
                        wake_q  <= '0;
                    end else begin
                        wake_q <= wake_q - 4'd1;
                    end
                end
                default: state_q <= StAwake;
            endcase
        end
    end

    assign dout16_o  = dout_q;
    assign awake_o   = (state_q == StAwake);
    assign standby_o = (state_q != StAwake);

endmodule

// File: rtl/spram_multibank.sv
// Linear memory built from 1..4 SPRAM banks: bank decode, byte lanes, read pipeline.
module spram_multibank
    import spram_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned IDLE_SLEEP  = 1024,
    parameter int unsigned WAKE_CYCLES = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic [NUM_BANKS-1:0]    bank_standby_o
);

    localparam int unsigned BankBits = clog2(NUM_BANKS);
    localparam int unsigned SelW     = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned LaneBits = (DATA_WIDTH == 8) ? 1 : 0;

    if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : g_bad_banks
        $error("spram_multibank: NUM_BANKS must be 1, 2 or 4");
    end
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16) begin : g_bad_width
        $error("spram_multibank: DATA_WIDTH must be 8 or 16");
    end
    if (ADDR_WIDTH != SPRAM_ROW_BITS + BankBits + LaneBits) begin : g_bad_addr
        $error("spram_multibank: ADDR_WIDTH does not match NUM_BANKS/DATA_WIDTH");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15) begin : g_bad_wake
        $error("spram_multibank: WAKE_CYCLES must be 1..15");
    end

    logic [SelW-1:0]            bank;
    logic [SPRAM_ROW_BITS-1:0]  row;
    logic [SPRAM_DATA_BITS-1:0] din16;
    logic [SPRAM_MASK_BITS-1:0] mask4;
    logic                       lane;
    logic                       accept;
    logic [NUM_BANKS-1:0]       sel;
    logic [NUM_BANKS-1:0]       hit;
    logic [NUM_BANKS-1:0]       awake;
    logic [SPRAM_DATA_BITS-1:0] dout [NUM_BANKS];
    logic [SPRAM_DATA_BITS-1:0] dout_sel;
    logic                       rvalid_q;
    logic [SelW-1:0]            rbank_q;
    logic                       rlane_q;

    if (NUM_BANKS > 1) begin : g_bank_dec
        assign bank = addr_i[ADDR_WIDTH-1 -: BankBits];
    end else begin : g_bank_one
        assign bank = '0;
    end

    assign row = addr_i[LaneBits +: SPRAM_ROW_BITS];

    if (DATA_WIDTH == 8) begin : g_w8
        assign din16 = {wdata_i, wdata_i};
        assign mask4 = wmask_i[0] ? (addr_i[0] ? 4'b1100 : 4'b0011) : 4'b0000;
        assign lane  = addr_i[0];
    end else begin : g_w16
        assign din16 = wdata_i;
        assign mask4 = {wmask_i[1], wmask_i[1], wmask_i[0], wmask_i[0]};
        assign lane  = 1'b0;
    end

    assign ready_o = awake[bank];
    assign accept  = req_i & ready_o;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign sel[b] = accept & (bank == SelW'(b));
        assign hit[b] = req_i & (bank == SelW'(b));

        spram_bank #(
            .IDLE_SLEEP  (IDLE_SLEEP),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_bank (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .sel_i     (sel[b]),
            .hit_i     (hit[b]),
            .we_i      (we_i),
            .row_i     (row),
            .din16_i   (din16),
            .mask4_i   (mask4),
            .dout16_o  (dout[b]),
            .awake_o   (awake[b]),
            .standby_o (bank_standby_o[b])
        );
    end

    // Remember which bank/lane a read came from; reset drops any in-flight read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rbank_q  <= '0;
            rlane_q  <= 1'b0;
        end else begin
            rvalid_q <= accept & ~we_i;
            if (accept & ~we_i) begin
                rbank_q <= bank;
                rlane_q <= lane;
            end
        end
    end

    assign dout_sel = dout[rbank_q];
    assign rvalid_o = rvalid_q;

    if (DATA_WIDTH == 8) begin : g_rd8
        assign rdata_o = rlane_q ? dout_sel[15:8] : dout_sel[7:0];
    end else begin : g_rd16
        assign rdata_o = dout_sel;
    end

endmodule
